seq_pattern_gen: RTL and testbench

//  Serial pattern transmitter, the driving end of the 1-bit sequence detectors
//  (e.g. detect_1011). It accepts a parallel pattern over a valid/ready handshake
//  and shifts it out MSB-first on a 1-bit stream, repeating it a programmed number
//  of times. Bursts are back-to-back, so overlapping detection can be exercised.
//  The block replaces free-running rotate registers in detector benches and SoC

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_pattern_gen_if.sv | 29 ++
 rtl/piso_shift.sv | 32 +++
 rtl/seq_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types, default parameters and helpers for seq_pattern_gen.
//   state_e  - transmitter FSM states
//   eff_len  - maps a requested pattern length onto the length actually sent
package seq_gen_pkg;

   localparam int unsigned WidthDef  = 6;
   localparam int unsigned LenWDef   = 3;
   localparam int unsigned RepWDef   = 4;
   localparam int unsigned GapCycDef = 2;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   // 0 or anything longer than the register means "use the whole register".
   function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
      return ((len == 0) || (len > width)) ? width : len;
   endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request/stream bundle of the serial pattern transmitter.
//   master - requester side: drives pat/len/rep/start/stop, observes status and stream
//   slave  - transmitter side
interface seq_pattern_gen_if #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned LEN_W = 3,
   parameter int unsigned REP_W = 4
);
   logic [WIDTH-1:0] pat_i;
   logic [LEN_W-1:0] len_i;
   logic [REP_W-1:0] rep_i;
   logic             start_i;
   logic             ready_o;
   logic             stop_i;
   logic             seq_o;
   logic             seq_vld_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output pat_i, len_i, rep_i, start_i, stop_i,
      input  ready_o, seq_o, seq_vld_o, busy_o, done_o
   );

   modport slave (
      input  pat_i, len_i, rep_i, start_i, stop_i,
      output ready_o, seq_o, seq_vld_o, busy_o, done_o
   );
endinterface

// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out register, MSB shifted out first.
//   clk_i, rst_i - clock, synchronous active-high reset
//   load_i       - load data_i (has priority over shift_i)
//   shift_i      - shift left by one, zero fill
//   data_i       - parallel load value
//   msb_o        - current serial bit (register MSB)
module piso_shift #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_q <= '0;
      end else if (load_i) begin
         r_q <= data_i;
      end else if (shift_i) begin
         r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb_o = r_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: shifts a latched parallel pattern out MSB-first, repeating it
// rep times back-to-back (rep=0: until stop), then idles GAP_CYC cycles.
//   clk_i, rst_i - clock, synchronous active-high reset
//   bus_io       - request handshake (pat/len/rep/start/ready), stop, serial
//                  stream (seq/seq_vld) and status (busy/done)
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH   = WidthDef,
   parameter int unsigned LEN_W   = LenWDef,
   parameter int unsigned REP_W   = RepWDef,
   parameter int unsigned GAP_CYC = GapCycDef
) (
   input logic              clk_i,
   input logic              rst_i,
   seq_pattern_gen_if.slave bus_io
);

   localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_e           r_state;
   logic [WIDTH-1:0] r_pat;      // pattern left-aligned so bit L-1 sits at the MSB
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_bit_cnt;  // bits left in this repetition after the current one
   logic [REP_W-1:0] r_rep;      // 0 means unbounded and is never decremented
   logic [GapW-1:0]  r_gap_cnt;
   logic             r_vld;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;

   logic [LEN_W-1:0] w_len_eff;
   int unsigned      w_pad;
   logic [WIDTH-1:0] w_pat_aligned;
   logic             w_accept;
   logic             w_more;
   logic             w_load;
   logic             w_shift;
   logic [WIDTH-1:0] w_load_data;
   logic             w_seq;

   assign w_len_eff     = LEN_W'(eff_len(32'(bus_io.len_i), WIDTH));
   assign w_pad         = WIDTH - 32'(w_len_eff);
   assign w_pat_aligned = bus_io.pat_i << w_pad;
   assign w_accept      = (r_state == StIdle) && bus_io.start_i && !bus_io.stop_i;
   assign w_more        = (r_rep == '0) || (r_rep > REP_W'(1));

   // Shifter control; leaving SHIFT loads zero so seq_o stays a plain flop output.
   always_comb begin
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_load_data = '0;
      if (w_accept) begin
         w_load      = 1'b1;
         w_load_data = w_pat_aligned;
      end else if (r_state == StShift) begin
         if (bus_io.stop_i) begin
            w_load = 1'b1;
         end else if (r_bit_cnt != '0) begin
            w_shift = 1'b1;
         end else if (w_more) begin
            w_load      = 1'b1;
            w_load_data = r_pat;
         end else begin
            w_load = 1'b1;
         end
      end
   end

   piso_shift #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (w_load),
      .shift_i (w_shift),
      .data_i  (w_load_data),
      .msb_o   (w_seq)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_pat     <= '0;
         r_len     <= '0;
         r_bit_cnt <= '0;
         r_rep     <= '0;
         r_gap_cnt <= '0;
         r_vld     <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_pat     <= w_pat_aligned;
                  r_len     <= w_len_eff;
                  r_bit_cnt <= w_len_eff - LEN_W'(1);
                  r_rep     <= bus_io.rep_i;
                  r_state   <= StShift;
                  r_vld     <= 1'b1;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            StShift: begin
               if (bus_io.stop_i) begin
                  r_state <= StIdle;
                  r_vld   <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_bit_cnt != '0) begin
                  r_bit_cnt <= r_bit_cnt - LEN_W'(1);
               end else if (w_more) begin
                  r_bit_cnt <= r_len - LEN_W'(1);
                  if (r_rep > REP_W'(1)) begin
                     r_rep <= r_rep - REP_W'(1);
                  end
               end else begin
                  r_done <= 1'b1;
                  r_vld  <= 1'b0;
                  if (GAP_CYC == 0) begin
                     r_state <= StIdle;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= StGap;
                     r_gap_cnt <= GapW'(GAP_CYC - 1);
                  end
               end
            end
            StGap: begin
               if (bus_io.stop_i || (r_gap_cnt == '0)) begin
                  r_state <= StIdle;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GapW'(1);
               end
            end
            default: begin
               r_state <= StIdle;
               r_vld   <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_io.seq_o     = w_seq;
   assign bus_io.seq_vld_o = r_vld;
   assign bus_io.ready_o   = r_ready;
   assign bus_io.busy_o    = r_busy;
   assign bus_io.done_o    = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed scenarios plus random traffic, every cycle compared
// against a queue of expected per-cycle outputs built from accepted requests.
module tb_seq_pattern_gen;

   localparam int unsigned WIDTH   = 6;
   localparam int unsigned LEN_W   = 3;
   localparam int unsigned REP_W   = 4;
   localparam int unsigned GAP_CYC = 2;

   typedef struct packed {
      logic seq;
      logic vld;
      logic busy;
      logic ready;
      logic done;
   } exp_t;

   localparam exp_t IdleExp = '{seq: 1'b0, vld: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_pattern_gen_if #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W),
      .REP_W (REP_W)
   ) bus ();

   seq_pattern_gen #(
      .WIDTH   (WIDTH),
      .LEN_W   (LEN_W),
      .REP_W   (REP_W),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   // Reference model state: expected outputs for the current and coming cycles.
   exp_t             q[$];
   logic [WIDTH-1:0] m_pat;
   int               m_len;
   bit               m_inf;

   int n_checks = 0;
   int n_errors = 0;

   // Observed stream statistics for the directed scenarios.
   logic [31:0] s_bits;
   logic [3:0]  s_win;
   int          s_n, s_done, s_det;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void push_rep();
      exp_t e;
      for (int i = m_len - 1; i >= 0; i--) begin
         e = '{seq: m_pat[i], vld: 1'b1, busy: 1'b1, ready: 1'b0, done: 1'b0};
         q.push_back(e);
      end
   endfunction

   function automatic void push_gap();
      exp_t e;
      for (int g = 0; g < int'(GAP_CYC); g++) begin
         e = '{seq: 1'b0, vld: 1'b0, busy: 1'b1, ready: 1'b0, done: (g == 0)};
         q.push_back(e);
      end
   endfunction

   task automatic clr_stream();
      s_bits = '0;
      s_win  = '0;
      s_n    = 0;
      s_done = 0;
      s_det  = 0;
   endtask

   task automatic drive(input logic st, input logic sp, input logic [WIDTH-1:0] p,
                        input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r);
      bus.start_i = st;
      bus.stop_i  = sp;
      bus.pat_i   = p;
      bus.len_i   = l;
      bus.rep_i   = r;
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      exp_t e;
      int   l;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_inf = 0;
      end else if (q.size() != 0) begin
         void'(q.pop_front());
         if (bus.stop_i) begin
            q.delete();
            m_inf = 0;
         end else if (m_inf && q.size() == 0) begin
            push_rep();
         end
      end else if (bus.start_i && !bus.stop_i) begin
         l     = int'(bus.len_i);
         m_len = (l == 0 || l > int'(WIDTH)) ? int'(WIDTH) : l;
         m_pat = bus.pat_i;
         m_inf = (bus.rep_i == 0);
         if (m_inf) begin
            push_rep();
         end else begin
            for (int r = 0; r < int'(bus.rep_i); r++) push_rep();
            push_gap();
         end
      end
      #1;
      e = (q.size() != 0) ? q[0] : IdleExp;
      check_eq("seq_o", 32'(bus.seq_o), 32'(e.seq));
      check_eq("seq_vld_o", 32'(bus.seq_vld_o), 32'(e.vld));
      check_eq("busy_o", 32'(bus.busy_o), 32'(e.busy));
      check_eq("ready_o", 32'(bus.ready_o), 32'(e.ready));
      check_eq("done_o", 32'(bus.done_o), 32'(e.done));
      if (bus.seq_vld_o === 1'b1) begin
         s_bits = {s_bits[30:0], bus.seq_o};
         s_win  = {s_win[2:0], bus.seq_o};
         s_n++;
         if (s_n >= 4 && s_win == 4'b1011) s_det++;
      end
      if (bus.done_o === 1'b1) s_done++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [31:0] rnd;
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      clr_stream();

      // Reset held for three cycles.
      run(3);
      rst = 1'b0;
      run(1);

      // Single burst: 4-bit pattern 1011, one repetition, then the gap.
      clr_stream();
      drive(1'b1, 1'b0, 6'b001011, 3'd4, 4'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      run(8);
      check_eq("single_bits", s_bits, 32'b1011);
      check_eq("single_nbits", 32'(s_n), 32'd4);
      check_eq("single_done", 32'(s_done), 32'd1);

      // Back-to-back repetitions, detector hits including the overlap.
      clr_stream();
      drive(1'b1, 1'b0, 6'b001011, 3'd4, 4'd3);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      run(16);
      check_eq("b2b_bits", s_bits, 32'b101110111011);
      check_eq("b2b_nbits", 32'(s_n), 32'd12);
      check_eq("b2b_detect", 32'(s_det), 32'd3);
      check_eq("b2b_done", 32'(s_done), 32'd1);

      // Unbounded stream with len=0 (full width), aborted at bit 9.
      clr_stream();
      drive(1'b1, 1'b0, 6'b110110, 3'd0, 4'd0);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      run(9);
      bus.stop_i = 1'b1;
      step();
      bus.stop_i = 1'b0;
      check_eq("abort_vld", 32'(bus.seq_vld_o), 32'd0);
      check_eq("abort_ready", 32'(bus.ready_o), 32'd1);
      check_eq("abort_nbits", 32'(s_n), 32'd10);
      check_eq("abort_bits", s_bits & 32'h3ff, 32'b1101101101);
      run(3);
      check_eq("abort_done", 32'(s_done), 32'd0);

      // Start while busy is ignored.
      clr_stream();
      drive(1'b1, 1'b0, 6'b101100, 3'd4, 4'd2);
      step();
      drive(1'b1, 1'b0, 6'b010011, 3'd3, 4'd1);
      run(3);
      drive(1'b0, 1'b0, '0, '0, '0);
      run(10);
      check_eq("busy_start_bits", s_bits, 32'b11001100);
      check_eq("busy_start_nbits", 32'(s_n), 32'd8);

      // start and stop together in IDLE: no transfer.
      clr_stream();
      drive(1'b1, 1'b1, 6'b111111, 3'd2, 4'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      check_eq("startstop_busy", 32'(bus.busy_o), 32'd0);
      run(3);
      check_eq("startstop_nbits", 32'(s_n), 32'd0);

      // Reset mid-transfer, then a fresh start begins from the top bit.
      drive(1'b1, 1'b0, 6'b001011, 3'd4, 4'd2);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      run(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_vld", 32'(bus.seq_vld_o), 32'd0);
      clr_stream();
      drive(1'b1, 1'b0, 6'b001011, 3'd4, 4'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      check_eq("restart_first", 32'(bus.seq_o), 32'd1);
      run(7);
      check_eq("restart_bits", s_bits, 32'b1011);

      // Random traffic, including L=1, over-long lengths, stops and resets.
      for (int c = 0; c < 1500; c++) begin
         rnd = $urandom();
         rst = ($urandom_range(0, 299) == 0);
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), rnd[WIDTH-1:0],
               LEN_W'($urandom_range(0, 7)), REP_W'($urandom_range(0, 3)));
         step();
      end
      rst = 1'b0;
      drive(1'b0, 1'b1, '0, '0, '0);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      run(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
